// File: rtl/control_pkg.sv
// Shared encodings for the CPU control path: ALU operations, next-PC/writeback
// selects, opcode/funct constants and the packed control bundle.
package control_pkg;

    typedef enum logic [5:0] {
        ALU_ADD = 6'b000000,
        ALU_SUB = 6'b000001,
        ALU_AND = 6'b011000,
        ALU_OR  = 6'b011110,
        ALU_XOR = 6'b010110,
        ALU_NOR = 6'b010001,
        ALU_SLL = 6'b100000,
        ALU_SRL = 6'b100001,
        ALU_SRA = 6'b100011,
        ALU_EQ  = 6'b110011,
        ALU_NEQ = 6'b110001,
        ALU_LT  = 6'b110101,
        ALU_LEZ = 6'b111101,
        ALU_LTZ = 6'b111011,
        ALU_GTZ = 6'b111111
    } alu_fun_t;

    typedef enum logic [2:0] {
        PC_NEXT   = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_REG    = 3'd3,
        PC_ILLOP  = 3'd4,
        PC_IRQ    = 3'd5
    } pc_src_t;

    typedef enum logic [1:0] {
        DST_RD = 2'd0,
        DST_RT = 2'd1,
        DST_RA = 2'd2,
        DST_K0 = 2'd3
    } reg_dst_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } mem_to_reg_t;

    typedef enum logic {
        MODE_USER   = 1'b0,
        MODE_KERNEL = 1'b1
    } mode_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BLTZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BLEZ  = 6'h06;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef struct packed {
        pc_src_t     pc_src;
        reg_dst_t    reg_dst;
        logic        reg_wr;
        logic        alu_src1;
        logic        alu_src2;
        alu_fun_t    alu_fun;
        logic        mem_wr;
        logic        mem_rd;
        mem_to_reg_t mem_to_reg;
        logic        ext_op;
        logic        lu_op;
    } ctrl_t;

    // Values every field takes when an instruction does not use it.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c.pc_src     = PC_NEXT;
        c.reg_dst    = DST_RD;
        c.reg_wr     = 1'b0;
        c.alu_src1   = 1'b0;
        c.alu_src2   = 1'b0;
        c.alu_fun    = ALU_ADD;
        c.mem_wr     = 1'b0;
        c.mem_rd     = 1'b0;
        c.mem_to_reg = WB_ALU;
        c.ext_op     = 1'b1;
        c.lu_op      = 1'b0;
        return c;
    endfunction

    // Trap entry: vector the PC and save PC+4 into $k0.
    function automatic ctrl_t ctrl_trap(input pc_src_t vector);
        ctrl_t c;
        c            = ctrl_idle();
        c.pc_src     = vector;
        c.reg_dst    = DST_K0;
        c.reg_wr     = 1'b1;
        c.mem_to_reg = WB_PC4;
        return c;
    endfunction

endpackage

// File: rtl/control_decode.sv
// Pure combinational instruction decode; flags unknown encodings and register
// jumps so the top can apply the exception override and kernel-mode exit.
module control_decode
    import control_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl,
    output logic       illegal,
    output logic       reg_jump
);

    always_comb begin
        ctrl     = ctrl_idle();
        illegal  = 1'b0;
        reg_jump = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_dst    = DST_RD;
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = WB_ALU;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_fun = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_fun = ALU_SUB;
                    FN_AND:          ctrl.alu_fun = ALU_AND;
                    FN_OR:           ctrl.alu_fun = ALU_OR;
                    FN_XOR:          ctrl.alu_fun = ALU_XOR;
                    FN_NOR:          ctrl.alu_fun = ALU_NOR;
                    FN_SLT, FN_SLTU: ctrl.alu_fun = ALU_LT;
                    FN_SLL: begin
                        ctrl.alu_src1 = 1'b1;
                        ctrl.alu_fun  = ALU_SLL;
                    end
                    FN_SRL: begin
                        ctrl.alu_src1 = 1'b1;
                        ctrl.alu_fun  = ALU_SRL;
                    end
                    FN_SRA: begin
                        ctrl.alu_src1 = 1'b1;
                        ctrl.alu_fun  = ALU_SRA;
                    end
                    FN_JR: begin
                        ctrl.pc_src = PC_REG;
                        ctrl.reg_wr = 1'b0;
                        reg_jump    = 1'b1;
                    end
                    FN_JALR: begin
                        ctrl.pc_src     = PC_REG;
                        ctrl.mem_to_reg = WB_PC4;
                        reg_jump        = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_LW: begin
                ctrl.alu_src2   = 1'b1;
                ctrl.mem_rd     = 1'b1;
                ctrl.mem_to_reg = WB_MEM;
                ctrl.reg_dst    = DST_RT;
                ctrl.reg_wr     = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src2 = 1'b1;
                ctrl.mem_wr   = 1'b1;
            end
            OP_LUI, OP_ADDI, OP_ADDIU, OP_ANDI, OP_SLTI, OP_SLTIU: begin
                ctrl.reg_dst  = DST_RT;
                ctrl.reg_wr   = 1'b1;
                ctrl.alu_src2 = 1'b1;
                if (opcode == OP_LUI) begin
                    ctrl.lu_op = 1'b1;
                end else if (opcode == OP_ANDI) begin
                    ctrl.ext_op  = 1'b0;
                    ctrl.alu_fun = ALU_AND;
                end else if (opcode == OP_SLTI || opcode == OP_SLTIU) begin
                    ctrl.alu_fun = ALU_LT;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ: begin
                ctrl.pc_src = PC_BRANCH;
                case (opcode)
                    OP_BEQ:  ctrl.alu_fun = ALU_EQ;
                    OP_BNE:  ctrl.alu_fun = ALU_NEQ;
                    OP_BLEZ: ctrl.alu_fun = ALU_LEZ;
                    OP_BGTZ: ctrl.alu_fun = ALU_GTZ;
                    default: ctrl.alu_fun = ALU_LTZ;
                endcase
            end
            OP_J: begin
                ctrl.pc_src = PC_JUMP;
            end
            OP_JAL: begin
                ctrl.pc_src     = PC_JUMP;
                ctrl.reg_dst    = DST_RA;
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_to_reg = WB_PC4;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl = ctrl_idle();
        end
    end

endmodule

// File: rtl/control.sv
// CPU control unit: instruction decode plus the kernel-mode bit that gates
// interrupts and the interrupt/illegal-op trap override.
module control
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       IRQ,
    output logic [2:0] PCSrc,
    output logic [1:0] RegDst,
    output logic       RegWr,
    output logic       ALUSrc1,
    output logic       ALUSrc2,
    output logic [5:0] ALUFun,
    output logic       MemWr,
    output logic       MemRd,
    output logic [1:0] MemToReg,
    output logic       EXTOp,
    output logic       LUOp
);

    mode_t mode;
    ctrl_t dec;
    ctrl_t ctrl;
    logic  illegal;
    logic  reg_jump;
    logic  take_irq;

    control_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .ctrl     (dec),
        .illegal  (illegal),
        .reg_jump (reg_jump)
    );

    assign take_irq = IRQ && (mode == MODE_USER);

    // Interrupt wins over an illegal-op trap; both replace the instruction.
    always_comb begin
        ctrl = dec;
        if (take_irq) begin
            ctrl = ctrl_trap(PC_IRQ);
        end else if (illegal) begin
            ctrl = ctrl_trap(PC_ILLOP);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode <= MODE_USER;
        end else if (take_irq || illegal) begin
            mode <= MODE_KERNEL;
        end else if (reg_jump) begin
            mode <= MODE_USER;
        end
    end

    assign PCSrc    = ctrl.pc_src;
    assign RegDst   = ctrl.reg_dst;
    assign RegWr    = ctrl.reg_wr;
    assign ALUSrc1  = ctrl.alu_src1;
    assign ALUSrc2  = ctrl.alu_src2;
    assign ALUFun   = ctrl.alu_fun;
    assign MemWr    = ctrl.mem_wr;
    assign MemRd    = ctrl.mem_rd;
    assign MemToReg = ctrl.mem_to_reg;
    assign EXTOp    = ctrl.ext_op;
    assign LUOp     = ctrl.lu_op;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for the control unit: directed scenarios plus random
// instruction/IRQ streams against an instruction-table reference model.
module tb_control;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       IRQ = 1'b0;
    logic [2:0] PCSrc;
    logic [1:0] RegDst;
    logic       RegWr;
    logic       ALUSrc1;
    logic       ALUSrc2;
    logic [5:0] ALUFun;
    logic       MemWr;
    logic       MemRd;
    logic [1:0] MemToReg;
    logic       EXTOp;
    logic       LUOp;

    int n_cmp = 0;
    int n_bad = 0;
    bit kern = 1'b0;

    logic [19:0] obs;
    assign obs = {PCSrc, RegDst, RegWr, ALUSrc1, ALUSrc2, ALUFun,
                  MemWr, MemRd, MemToReg, EXTOp, LUOp};

    always #5 clk = ~clk;

    control dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .funct    (funct),
        .IRQ      (IRQ),
        .PCSrc    (PCSrc),
        .RegDst   (RegDst),
        .RegWr    (RegWr),
        .ALUSrc1  (ALUSrc1),
        .ALUSrc2  (ALUSrc2),
        .ALUFun   (ALUFun),
        .MemWr    (MemWr),
        .MemRd    (MemRd),
        .MemToReg (MemToReg),
        .EXTOp    (EXTOp),
        .LUOp     (LUOp)
    );

    // Returns {illegal, register_jump, 20-bit expected output bundle}.
    function automatic logic [21:0] model(input logic [5:0] op, input logic [5:0] fn,
                                          input logic irq, input bit k);
        logic [2:0] pc  = 3'd0;
        logic [1:0] dst = 2'd0;
        logic [5:0] alu = 6'b000000;
        logic [1:0] m2r = 2'd0;
        bit wr = 0, a1 = 0, a2 = 0, mw = 0, mr = 0, ext = 1, lu = 0;
        bit legal = 1, rj = 0;
        case (op)
            6'h00: begin
                wr = 1;
                case (fn)
                    6'h20, 6'h21: alu = 6'b000000;
                    6'h22, 6'h23: alu = 6'b000001;
                    6'h24: alu = 6'b011000;
                    6'h25: alu = 6'b011110;
                    6'h26: alu = 6'b010110;
                    6'h27: alu = 6'b010001;
                    6'h00: begin alu = 6'b100000; a1 = 1; end
                    6'h02: begin alu = 6'b100001; a1 = 1; end
                    6'h03: begin alu = 6'b100011; a1 = 1; end
                    6'h2A, 6'h2B: alu = 6'b110101;
                    6'h08: begin pc = 3; wr = 0; rj = 1; end
                    6'h09: begin pc = 3; m2r = 2; rj = 1; end
                    default: legal = 0;
                endcase
            end
            6'h23: begin a2 = 1; mr = 1; m2r = 1; dst = 1; wr = 1; end
            6'h2B: begin a2 = 1; mw = 1; end
            6'h0F: begin dst = 1; wr = 1; a2 = 1; lu = 1; end
            6'h08, 6'h09: begin dst = 1; wr = 1; a2 = 1; end
            6'h0C: begin dst = 1; wr = 1; a2 = 1; ext = 0; alu = 6'b011000; end
            6'h0A, 6'h0B: begin dst = 1; wr = 1; a2 = 1; alu = 6'b110101; end
            6'h04: begin pc = 1; alu = 6'b110011; end
            6'h05: begin pc = 1; alu = 6'b110001; end
            6'h06: begin pc = 1; alu = 6'b111101; end
            6'h07: begin pc = 1; alu = 6'b111111; end
            6'h01: begin pc = 1; alu = 6'b111011; end
            6'h02: pc = 2;
            6'h03: begin pc = 2; dst = 2; wr = 1; m2r = 2; end
            default: legal = 0;
        endcase
        if ((irq && !k) || !legal) begin
            pc  = (irq && !k) ? 3'd5 : 3'd4;
            dst = 3; wr = 1; m2r = 2;
            alu = 6'b000000; a1 = 0; a2 = 0; mw = 0; mr = 0; ext = 1; lu = 0;
        end
        return {!legal, rj, pc, dst, wr, a1, a2, alu, mw, mr, m2r, ext, lu};
    endfunction

    // Kernel bit as the architecture describes it, advanced on every edge.
    always @(posedge clk or negedge reset) begin : kernel_model
        logic [21:0] m;
        if (!reset) begin
            kern <= 1'b0;
        end else begin
            m = model(opcode, funct, IRQ, kern);
            if ((IRQ && !kern) || m[21]) kern <= 1'b1;
            else if (m[20]) kern <= 1'b0;
        end
    end

    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic irq);
        @(negedge clk);
        opcode = op;
        funct  = fn;
        IRQ    = irq;
        #1;
    endtask

    task automatic test_reset();
        logic [19:0] exp;
        reset = 1'b0; opcode = 6'h00; funct = 6'h20; IRQ = 1'b0;
        #2;
        exp = model(opcode, funct, IRQ, 1'b0);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++; $display("FAIL reset_add got=%h want=%h", obs, exp);
        end
        n_cmp++;
        if ({PCSrc, RegDst, RegWr, ALUFun, MemToReg} !== {3'd0, 2'd0, 1'b1, 6'b000000, 2'd0}) begin
            n_bad++; $display("FAIL reset_fields got=%h want=%h",
                              {PCSrc, RegDst, RegWr, ALUFun, MemToReg}, {3'd0, 2'd0, 1'b1, 6'b000000, 2'd0});
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_decode();
        logic [11:0] tbl [0:29] = '{
            {6'h00, 6'h20}, {6'h00, 6'h21}, {6'h00, 6'h22}, {6'h00, 6'h23}, {6'h00, 6'h24},
            {6'h00, 6'h25}, {6'h00, 6'h26}, {6'h00, 6'h27}, {6'h00, 6'h00}, {6'h00, 6'h02},
            {6'h00, 6'h03}, {6'h00, 6'h2A}, {6'h00, 6'h2B}, {6'h00, 6'h08}, {6'h00, 6'h09},
            {6'h23, 6'h11}, {6'h2B, 6'h05}, {6'h0F, 6'h3F}, {6'h08, 6'h00}, {6'h09, 6'h20},
            {6'h0C, 6'h01}, {6'h0A, 6'h08}, {6'h0B, 6'h00}, {6'h04, 6'h00}, {6'h05, 6'h2A},
            {6'h06, 6'h00}, {6'h07, 6'h09}, {6'h01, 6'h00}, {6'h02, 6'h00}, {6'h03, 6'h1F}};
        logic [19:0] exp;
        for (int i = 0; i < 30; i++) begin
            apply(tbl[i][11:6], tbl[i][5:0], 1'b0);
            exp = model(opcode, funct, IRQ, kern);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL decode op=%h fn=%h got=%h want=%h", opcode, funct, obs, exp);
            end
        end
        apply(6'h00, 6'h03, 1'b0);
        n_cmp++;
        if ({ALUSrc1, ALUFun} !== {1'b1, 6'b100011}) begin
            n_bad++; $display("FAIL sra got=%h want=%h", {ALUSrc1, ALUFun}, {1'b1, 6'b100011});
        end
        apply(6'h23, 6'h00, 1'b0);
        n_cmp++;
        if ({MemRd, MemToReg, ALUSrc2, RegDst} !== {1'b1, 2'd1, 1'b1, 2'd1}) begin
            n_bad++; $display("FAIL lw got=%h want=%h", {MemRd, MemToReg, ALUSrc2, RegDst}, {1'b1, 2'd1, 1'b1, 2'd1});
        end
        apply(6'h0C, 6'h00, 1'b0);
        n_cmp++;
        if ({EXTOp, ALUFun} !== {1'b0, 6'b011000}) begin
            n_bad++; $display("FAIL andi got=%h want=%h", {EXTOp, ALUFun}, {1'b0, 6'b011000});
        end
        apply(6'h0F, 6'h00, 1'b0);
        n_cmp++;
        if (LUOp !== 1'b1) begin
            n_bad++; $display("FAIL lui got=%b want=1", LUOp);
        end
        apply(6'h07, 6'h00, 1'b0);
        n_cmp++;
        if ({PCSrc, ALUFun, RegWr} !== {3'd1, 6'b111111, 1'b0}) begin
            n_bad++; $display("FAIL bgtz got=%h want=%h", {PCSrc, ALUFun, RegWr}, {3'd1, 6'b111111, 1'b0});
        end
        apply(6'h03, 6'h00, 1'b0);
        n_cmp++;
        if ({PCSrc, RegDst, MemToReg} !== {3'd2, 2'd2, 2'd2}) begin
            n_bad++; $display("FAIL jal got=%h want=%h", {PCSrc, RegDst, MemToReg}, {3'd2, 2'd2, 2'd2});
        end
        apply(6'h00, 6'h09, 1'b0);
        n_cmp++;
        if ({PCSrc, MemToReg} !== {3'd3, 2'd2}) begin
            n_bad++; $display("FAIL jalr got=%h want=%h", {PCSrc, MemToReg}, {3'd3, 2'd2});
        end
    endtask

    task automatic test_irq();
        apply(6'h00, 6'h08, 1'b0);
        apply(6'h2B, 6'h00, 1'b1);
        n_cmp++;
        if ({PCSrc, RegDst, MemWr} !== {3'd5, 2'd3, 1'b0}) begin
            n_bad++; $display("FAIL irq_take got=%h want=%h", {PCSrc, RegDst, MemWr}, {3'd5, 2'd3, 1'b0});
        end
        apply(6'h2B, 6'h00, 1'b1);
        n_cmp++;
        if ({PCSrc, RegWr, ALUSrc2, MemWr, EXTOp} !== {3'd0, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL irq_masked got=%h want=%h",
                              {PCSrc, RegWr, ALUSrc2, MemWr, EXTOp}, {3'd0, 1'b0, 1'b1, 1'b1, 1'b1});
        end
        apply(6'h00, 6'h08, 1'b0);
        apply(6'h00, 6'h20, 1'b1);
        n_cmp++;
        if (PCSrc !== 3'd5) begin
            n_bad++; $display("FAIL irq_after_jr got=%0d want=5", PCSrc);
        end
    endtask

    task automatic test_illegal();
        apply(6'h00, 6'h08, 1'b0);
        apply(6'h3F, 6'h00, 1'b0);
        n_cmp++;
        if ({PCSrc, RegDst, RegWr, MemToReg} !== {3'd4, 2'd3, 1'b1, 2'd2}) begin
            n_bad++; $display("FAIL illop got=%h want=%h", {PCSrc, RegDst, RegWr, MemToReg}, {3'd4, 2'd3, 1'b1, 2'd2});
        end
        apply(6'h3F, 6'h00, 1'b1);
        n_cmp++;
        if (PCSrc !== 3'd4) begin
            n_bad++; $display("FAIL illop_kernel got=%0d want=4", PCSrc);
        end
        apply(6'h00, 6'h01, 1'b0);
        n_cmp++;
        if (PCSrc !== 3'd4) begin
            n_bad++; $display("FAIL illegal_funct got=%0d want=4", PCSrc);
        end
        apply(6'h00, 6'h20, 1'b1);
        n_cmp++;
        if (PCSrc !== 3'd0) begin
            n_bad++; $display("FAIL kernel_kept got=%0d want=0", PCSrc);
        end
        apply(6'h00, 6'h08, 1'b0);
    endtask

    task automatic test_reset_mid_kernel();
        apply(6'h00, 6'h20, 1'b1);
        apply(6'h00, 6'h20, 1'b1);
        n_cmp++;
        if (PCSrc !== 3'd0) begin
            n_bad++; $display("FAIL in_kernel got=%0d want=0", PCSrc);
        end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({PCSrc, RegDst} !== {3'd5, 2'd3}) begin
            n_bad++; $display("FAIL async_reset got=%h want=%h", {PCSrc, RegDst}, {3'd5, 2'd3});
        end
        @(negedge clk);
        reset = 1'b1;
        IRQ = 1'b0;
    endtask

    task automatic test_random();
        logic [11:0] tbl [0:15] = '{
            {6'h00, 6'h20}, {6'h00, 6'h22}, {6'h00, 6'h27}, {6'h00, 6'h02}, {6'h00, 6'h2B},
            {6'h00, 6'h08}, {6'h00, 6'h09}, {6'h23, 6'h00}, {6'h2B, 6'h00}, {6'h0F, 6'h00},
            {6'h0C, 6'h00}, {6'h0B, 6'h00}, {6'h04, 6'h00}, {6'h01, 6'h00}, {6'h02, 6'h00},
            {6'h03, 6'h00}};
        logic [19:0] exp;
        logic [11:0] pick;
        logic [5:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 400; i++) begin
            pick = tbl[$urandom_range(0, 15)];
            op = pick[11:6];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pick[5:0];
            if ($urandom_range(0, 4) == 0) op = 6'($urandom);
            apply(op, fn, ($urandom_range(0, 3) == 0));
            exp = model(opcode, funct, IRQ, kern);
            n_cmp++;
            if (obs !== exp) begin
                n_bad++; $display("FAIL random op=%h fn=%h irq=%b got=%h want=%h",
                                  opcode, funct, IRQ, obs, exp);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_decode();
        test_irq();
        test_illegal();
        test_reset_mid_kernel();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control.md
CONTROL -- requirements
Module: control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Ports SHALL be connected by name only, in this order:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low
- opcode  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- IRQ  in  1  external interrupt request
- PCSrc  out  3  next-PC select: 0 PC+4, 1 branch target, 2 jump target, 3 register (rs), 4 illegal-op vector, 5 interrupt vector
- RegDst  out  2  write register: 0 rd, 1 rt, 2 $31, 3 $26 ($k0)
- RegWr  out  1  register-file write enable
- ALUSrc1  out  1  ALU A: 0 rs, 1 shamt
- ALUSrc2  out  1  ALU B: 0 rt, 1 extended immediate
- ALUFun  out  6  ALU operation code
- MemWr  out  1  data-memory write
- MemRd  out  1  data-memory read
- MemToReg  out  2  writeback source: 0 ALU, 1 memory, 2 PC+4
- EXTOp  out  1  immediate extension: 1 sign, 0 zero
- LUOp  out  1  1 = immediate shifted to upper 16 bits (lui)

Function
REQ-003 All outputs SHALL be combinational from opcode, funct, IRQ and the internal kernel bit, with zero-cycle latency.
REQ-004 ALUFun codes SHALL be: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, LTZ 111011, GTZ 111111.
REQ-005 The R-type set (opcode 00) SHALL be: funct 20/21 ADD, 22/23 SUB, 24 AND, 25 OR, 26 XOR, 27 NOR, 00 SLL, 02 SRL, 03 SRA, 2A/2B LT, 08 jr, 09 jalr.
- Arithmetic/logic: RegDst 0, RegWr 1, MemToReg 0.
- Shifts: same as arithmetic/logic, plus ALUSrc1 1.
REQ-006 jr SHALL give PCSrc 3, RegWr 0; jalr SHALL give PCSrc 3, RegDst 0, RegWr 1, MemToReg 2.
REQ-007 Loads and stores SHALL decode as:
- lw (23): ALUSrc2 1, EXTOp 1, ADD, MemRd 1, MemToReg 1, RegDst 1, RegWr 1.
- sw (2B): ALUSrc2 1, EXTOp 1, ADD, MemWr 1, RegWr 0.
REQ-008 Immediate ALU ops SHALL set RegDst 1, RegWr 1, ALUSrc2 1, MemToReg 0, and:
- lui (0F): LUOp 1, ADD.
- addi (08) / addiu (09): EXTOp 1, ADD.
- andi (0C): EXTOp 0, AND.
- slti (0A) / sltiu (0B): EXTOp 1, LT.
REQ-009 Branches SHALL set PCSrc 1, RegWr 0, ALUSrc2 0, EXTOp 1:
- beq (04): EQ; bne (05): NEQ; blez (06): LEZ; bgtz (07): GTZ; bltz (01): LTZ.
REQ-010 j (02) SHALL give PCSrc 2, RegWr 0; jal (03) SHALL give PCSrc 2, RegDst 2, RegWr 1, MemToReg 2.
REQ-011 Any other opcode/funct SHALL be illegal: PCSrc 4, RegDst 3, RegWr 1, MemToReg 2, MemRd 0, MemWr 0.
REQ-012 Interrupt SHALL be taken when IRQ=1 and kernel=0: PCSrc 5, RegDst 3, RegWr 1, MemToReg 2, MemRd 0, MemWr 0, overriding the instruction.
- Interrupt has priority over an illegal-op exception.
- IRQ SHALL be ignored while kernel=1.
REQ-013 Unused outputs SHALL be 0: ALUSrc1, ALUSrc2, LUOp, MemRd, MemWr; ALUFun ADD; EXTOp 1.
REQ-014 The kernel bit SHALL be set at the rising clk edge when an interrupt or exception is taken, and cleared at the edge on which jr or jalr executes with no interrupt taken.
REQ-015 An illegal op while kernel=1 SHALL still raise the exception; kernel stays 1.

Reset
REQ-016 reset=0 SHALL asynchronously clear kernel to 0; outputs then follow REQ-003 to REQ-013 combinationally.

Structure
REQ-017 ALUFun, PCSrc, RegDst, MemToReg codes and the opcode/funct constants SHALL live in a shared package, reused by the ALU and datapath.
REQ-018 Sub-module control_decode SHALL hold the combinational instruction decode; the top SHALL hold the kernel register and the interrupt/exception override.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- After reset, IRQ=0, opcode 00 funct 20 -> PCSrc 0, RegDst 0, RegWr 1, ALUFun 000000, MemToReg 0.
- opcode 00 funct 03 -> ALUSrc1 1, ALUFun 100011; opcode 23 -> MemRd 1, MemToReg 1, ALUSrc2 1, RegDst 1.
- opcode 0C -> EXTOp 0, ALUFun 011000; opcode 0F -> LUOp 1; opcode 07 -> PCSrc 1, ALUFun 111111, RegWr 0.
- opcode 03 -> PCSrc 2, RegDst 2, MemToReg 2; opcode 00 funct 09 -> PCSrc 3, MemToReg 2.
- IRQ=1 with opcode 2B -> PCSrc 5, RegDst 3, MemWr 0; after one clk, IRQ=1 -> normal sw decode; jr plus clk, then IRQ=1 -> PCSrc 5.
- opcode 3F -> PCSrc 4, RegDst 3, RegWr 1; reset asserted mid-kernel -> kernel 0 immediately.
